receptor_afisaj_multiplexat: RTL and testbench

- Receiving end of the multiplexed 4-digit 7-segment display bus: samples the digit enables D1..D4 and the segment lines a..g on every clock.
- Rebuilds the four digit codes and decodes the display mode: speed value, left turn, right turn or stop.
- Used as an on-chip loopback monitor of the display driver and as the verification observer for it.
- Sits beside the display driver on the same clock.

---
 rtl/receptor_afisaj_multiplexat.sv | 244 ++++++++++++++++++++++++
 tb/tb_receptor_afisaj_multiplexat.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/receptor_afisaj_multiplexat.sv
// Receiving end of a multiplexed 4-digit 7-segment display bus.
// Rebuilds the digit codes from the scanned segment lines, classifies each
// completed frame (speed, left, right, stop) and commits the mode once it has
// been seen NR_CADRE_STABIL times in a row. Also flags a silent link.
module receptor_afisaj_multiplexat #(
    parameter int NR_CADRE_STABIL = 2,
    parameter int TIMEOUT_CICLURI = 64
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       D1,
    input  logic       D2,
    input  logic       D3,
    input  logic       D4,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    input  logic       e,
    input  logic       f,
    input  logic       g,
    output logic [3:0] cod_digit_1,
    output logic [3:0] cod_digit_2,
    output logic [3:0] cod_digit_3,
    output logic [3:0] cod_digit_4,
    output logic       cadru_valid,
    output logic       eroare_cadru,
    output logic [3:0] cifra_zeci,
    output logic [3:0] cifra_unitati,
    output logic       semnal_stanga,
    output logic       semnal_dreapta,
    output logic       stop,
    output logic       semnal_activ
);
    localparam int STAB_W = $clog2(NR_CADRE_STABIL + 1);
    localparam int TOUT_W = $clog2(TIMEOUT_CICLURI + 1);
    localparam logic [STAB_W-1:0] STAB_MAX  = STAB_W'(NR_CADRE_STABIL);
    localparam logic [TOUT_W-1:0] TOUT_LAST = TOUT_W'(TIMEOUT_CICLURI - 1);
    localparam logic [3:0] COD_RIGHT = 4'd10;
    localparam logic [3:0] COD_LEFT  = 4'd11;
    localparam logic [3:0] COD_DASH  = 4'd12;
    localparam logic [3:0] COD_BLANK = 4'd13;

    typedef enum logic [1:0] {MOD_VITEZA, MOD_STANGA, MOD_DREAPTA, MOD_STOP} mod_e;
    typedef struct packed {
        logic valid;
        mod_e mod;
    } clasa_t;

    // Segment lines are active low; the "3" pattern doubles as the right
    // marker when it appears on the last digit.
    function automatic logic [3:0] decode_seg(input logic [6:0] seg, input logic on_d4);
        logic [3:0] cod;
        case (seg)
            7'b0000001: cod = 4'd0;
            7'b1001111: cod = 4'd1;
            7'b0010010: cod = 4'd2;
            7'b0000110: cod = on_d4 ? COD_RIGHT : 4'd3;
            7'b1001100: cod = 4'd4;
            7'b0100100: cod = 4'd5;
            7'b0100000: cod = 4'd6;
            7'b0001111: cod = 4'd7;
            7'b0000000: cod = 4'd8;
            7'b0000100: cod = 4'd9;
            7'b0110000: cod = COD_LEFT;
            7'b1111110: cod = COD_DASH;
            7'b1111111: cod = COD_BLANK;
            default:    cod = 4'd15;
        endcase
        return cod;
    endfunction

    function automatic clasa_t classify(input logic [3:0] d1, d2, d3, d4);
        clasa_t cl;
        cl.valid = 1'b0;
        cl.mod   = MOD_VITEZA;
        if (d1 == 4'd8 && d2 == 4'd8 && d3 == 4'd8 && d4 == 4'd8) begin
            cl.valid = 1'b1;
            cl.mod   = MOD_STOP;
        end else if (d1 == COD_LEFT && d2 == COD_DASH && d3 == COD_DASH && d4 == COD_DASH) begin
            cl.valid = 1'b1;
            cl.mod   = MOD_STANGA;
        end else if (d1 == COD_DASH && d2 == COD_DASH && d3 == COD_DASH && d4 == COD_RIGHT) begin
            cl.valid = 1'b1;
            cl.mod   = MOD_DREAPTA;
        end else if (d1 == COD_BLANK && d4 == COD_BLANK && d3 <= 4'd9 &&
                     (d2 == COD_BLANK || (d2 >= 4'd1 && d2 <= 4'd9))) begin
            cl.valid = 1'b1;
            cl.mod   = MOD_VITEZA;
        end
        return cl;
    endfunction

    logic [3:0]        sel;
    logic [6:0]        seg;
    logic [3:0]        cod_nou;
    logic              selectie_unica, selectie_ilegala, cadru_gata;
    clasa_t            clasa;
    logic [15:0]       tuplu;

    logic [3:0]        slot_q [4];
    logic [3:0]        slot_d [4];
    logic [3:0]        cod_q [4];
    logic [3:0]        cod_d [4];
    logic [3:0]        mask_q, mask_d;
    logic [STAB_W-1:0] stab_q, stab_d;
    logic [15:0]       prev_q, prev_d;
    logic [TOUT_W-1:0] tout_q, tout_d;
    logic              cadru_valid_q, cadru_valid_d;
    logic              eroare_q, eroare_d;
    logic [3:0]        zeci_q, zeci_d, unit_q, unit_d;
    logic              stanga_q, stanga_d, dreapta_q, dreapta_d;
    logic              stop_q, stop_d, activ_q, activ_d;

    assign sel              = {D4, D3, D2, D1};
    assign seg              = {a, b, c, d, e, f, g};
    assign cod_nou          = decode_seg(seg, D4);
    assign selectie_unica   = $onehot(sel);
    assign selectie_ilegala = !$onehot0(sel);
    assign cadru_gata       = (mask_q == 4'b1111);
    assign clasa            = classify(slot_q[0], slot_q[1], slot_q[2], slot_q[3]);
    assign tuplu            = {slot_q[0], slot_q[1], slot_q[2], slot_q[3]};

    // Next-state: slot capture, frame emission, stability/commit, timeout.
    // NOTE: every variable gets a default at the top so no path leaves one unassigned (no latch).
    always_comb begin
        slot_d        = slot_q;
        cod_d         = cod_q;
        mask_d        = cadru_gata ? 4'b0000 : mask_q;
        stab_d        = stab_q;
        prev_d        = prev_q;
        tout_d        = tout_q;
        cadru_valid_d = 1'b0;
        eroare_d      = 1'b0;
        zeci_d        = zeci_q;
        unit_d        = unit_q;
        stanga_d      = stanga_q;
        dreapta_d     = dreapta_q;
        stop_d        = stop_q;
        activ_d       = activ_q;

        if (selectie_unica) begin
            for (int i = 0; i < 4; i++) begin
                if (sel[i]) slot_d[i] = cod_nou;
            end
            mask_d = mask_d | sel;
        end

        // An illegal selection also discards a frame waiting to be emitted.
        if (selectie_ilegala) begin
            mask_d   = 4'b0000;
            stab_d   = '0;
            eroare_d = 1'b1;
        end else if (cadru_gata) begin
            cod_d = slot_q;
            if (clasa.valid) begin
                cadru_valid_d = 1'b1;
                if (stab_q != '0 && tuplu == prev_q)
                    stab_d = (stab_q == STAB_MAX) ? stab_q : stab_q + 1'b1;
                else
                    stab_d = STAB_W'(1);
                prev_d = tuplu;
                if (stab_d == STAB_MAX) begin
                    activ_d   = 1'b1;
                    stanga_d  = (clasa.mod == MOD_STANGA);
                    dreapta_d = (clasa.mod == MOD_DREAPTA);
                    stop_d    = (clasa.mod == MOD_STOP);
                    if (clasa.mod == MOD_VITEZA) begin
                        zeci_d = (slot_q[1] == COD_BLANK) ? 4'd0 : slot_q[1];
                        unit_d = slot_q[2];
                    end
                end
            end else begin
                eroare_d = 1'b1;
                stab_d   = '0;
            end
        end

        // The watchdog restarts after firing so a resumed scan can lock again.
        if (cadru_valid_d) begin
            tout_d = '0;
        end else if (tout_q == TOUT_LAST) begin
            tout_d  = '0;
            activ_d = 1'b0;
            mask_d  = 4'b0000;
            stab_d  = '0;
        end else begin
            tout_d = tout_q + 1'b1;
        end
    end

    // Control state and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) cod_q[i] <= COD_BLANK;
            mask_q        <= '0;
            stab_q        <= '0;
            prev_q        <= '0;
            tout_q        <= '0;
            cadru_valid_q <= 1'b0;
            eroare_q      <= 1'b0;
            zeci_q        <= '0;
            unit_q        <= '0;
            stanga_q      <= 1'b0;
            dreapta_q     <= 1'b0;
            stop_q        <= 1'b0;
            activ_q       <= 1'b0;
        end else begin
            cod_q         <= cod_d;
            mask_q        <= mask_d;
            stab_q        <= stab_d;
            prev_q        <= prev_d;
            tout_q        <= tout_d;
            cadru_valid_q <= cadru_valid_d;
            eroare_q      <= eroare_d;
            zeci_q        <= zeci_d;
            unit_q        <= unit_d;
            stanga_q      <= stanga_d;
            dreapta_q     <= dreapta_d;
            stop_q        <= stop_d;
            activ_q       <= activ_d;
        end
    end

    // Slot storage for the frame under construction.
    // NOTE: no reset here on purpose; a slot is only read once its mask bit is set.
    always_ff @(posedge clock) begin
        slot_q <= slot_d;
    end

    assign cod_digit_1    = cod_q[0];
    assign cod_digit_2    = cod_q[1];
    assign cod_digit_3    = cod_q[2];
    assign cod_digit_4    = cod_q[3];
    assign cadru_valid    = cadru_valid_q;
    assign eroare_cadru   = eroare_q;
    assign cifra_zeci     = zeci_q;
    assign cifra_unitati  = unit_q;
    assign semnal_stanga  = stanga_q;
    assign semnal_dreapta = dreapta_q;
    assign stop           = stop_q;
    assign semnal_activ   = activ_q;
endmodule

// File: tb/tb_receptor_afisaj_multiplexat.sv
// Bench for receptor_afisaj_multiplexat: directed scenarios plus randomized
// frames, every cycle compared against a frame-level model of the display link.
module tb_receptor_afisaj_multiplexat;
    localparam int NR   = 2;
    localparam int TOUT = 64;

    logic clock = 1'b0;
    logic reset_n = 1'b1;
    logic D1 = 0, D2 = 0, D3 = 0, D4 = 0;
    logic a = 1, b = 1, c = 1, d = 1, e = 1, f = 1, g = 1;
    logic [3:0] cod_digit_1, cod_digit_2, cod_digit_3, cod_digit_4;
    logic [3:0] cifra_zeci, cifra_unitati;
    logic cadru_valid, eroare_cadru, semnal_stanga, semnal_dreapta, stop, semnal_activ;

    always #5 clock = ~clock;

    receptor_afisaj_multiplexat #(.NR_CADRE_STABIL(NR), .TIMEOUT_CICLURI(TOUT)) dut (
        .clock(clock), .reset_n(reset_n),
        .D1(D1), .D2(D2), .D3(D3), .D4(D4),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g),
        .cod_digit_1(cod_digit_1), .cod_digit_2(cod_digit_2),
        .cod_digit_3(cod_digit_3), .cod_digit_4(cod_digit_4),
        .cadru_valid(cadru_valid), .eroare_cadru(eroare_cadru),
        .cifra_zeci(cifra_zeci), .cifra_unitati(cifra_unitati),
        .semnal_stanga(semnal_stanga), .semnal_dreapta(semnal_dreapta),
        .stop(stop), .semnal_activ(semnal_activ)
    );

    int tests_run = 0;
    int tests_failed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests_run++;
        if (act !== req) begin
            tests_failed++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, req, $time);
        end
    endtask

    // Segment pattern per code (active low, a is the MSB); 14 and 15 are junk.
    logic [6:0] seg_tab [16] = '{7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
                                 7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
                                 7'b0000000, 7'b0000100, 7'b0000110, 7'b0110000,
                                 7'b1111110, 7'b1111111, 7'b0101010, 7'b0101010};

    // ---------------- reference model ----------------
    int m_slot [4];
    bit m_pres [4];
    bit m_pend;
    int m_cod [4];
    bit m_cv, m_er, m_st, m_dr, m_sp, m_act;
    int m_z, m_u, m_stab, m_idle;
    int m_prev [4];
    logic [29:0] exp_vec;
    bit chk_en = 0;

    function automatic int m_decode(logic [6:0] s, bit on_d4);
        if (on_d4 && s == seg_tab[10]) return 10;
        for (int k = 0; k < 14; k++)
            if (k != 10 && s == seg_tab[k]) return k;
        return 15;
    endfunction

    // 0 invalid, 1 speed, 2 left, 3 right, 4 stop
    function automatic int m_class(int d0, int d1, int d2, int d3);
        if (d0 == 8 && d1 == 8 && d2 == 8 && d3 == 8) return 4;
        if (d0 == 11 && d1 == 12 && d2 == 12 && d3 == 12) return 2;
        if (d0 == 12 && d1 == 12 && d2 == 12 && d3 == 10) return 3;
        if (d0 == 13 && d3 == 13 && (d1 == 13 || (d1 >= 1 && d1 <= 9)) && d2 >= 0 && d2 <= 9) return 1;
        return 0;
    endfunction

    function automatic logic [29:0] model_vec();
        return {4'(m_cod[0]), 4'(m_cod[1]), 4'(m_cod[2]), 4'(m_cod[3]), m_cv, m_er,
                4'(m_z), 4'(m_u), m_st, m_dr, m_sp, m_act};
    endfunction

    function automatic logic [29:0] dut_vec();
        return {cod_digit_1, cod_digit_2, cod_digit_3, cod_digit_4, cadru_valid, eroare_cadru,
                cifra_zeci, cifra_unitati, semnal_stanga, semnal_dreapta, stop, semnal_activ};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            m_pres[i] = 0; m_cod[i] = 13; m_prev[i] = 0; m_slot[i] = 0;
        end
        m_pend = 0; m_cv = 0; m_er = 0; m_st = 0; m_dr = 0; m_sp = 0; m_act = 0;
        m_z = 0; m_u = 0; m_stab = 0; m_idle = 0;
        exp_vec = model_vec();
    endtask

    task automatic model_step(input logic [3:0] sel, input logic [6:0] seg);
        int n = $countones(sel);
        m_cv = 0;
        m_er = 0;
        if (n >= 2) begin
            for (int i = 0; i < 4; i++) m_pres[i] = 0;
            m_pend = 0; m_stab = 0; m_er = 1;
        end else begin
            if (m_pend) begin
                int k = m_class(m_slot[0], m_slot[1], m_slot[2], m_slot[3]);
                bit same = (m_stab > 0);
                for (int i = 0; i < 4; i++) begin
                    m_cod[i] = m_slot[i];
                    if (m_prev[i] != m_slot[i]) same = 0;
                end
                if (k != 0) begin
                    m_cv = 1;
                    m_stab = same ? ((m_stab + 1 > NR) ? NR : m_stab + 1) : 1;
                    for (int i = 0; i < 4; i++) m_prev[i] = m_slot[i];
                    if (m_stab == NR) begin
                        m_act = 1;
                        m_st = (k == 2); m_dr = (k == 3); m_sp = (k == 4);
                        if (k == 1) begin
                            m_z = (m_slot[1] == 13) ? 0 : m_slot[1];
                            m_u = m_slot[2];
                        end
                    end
                end else begin
                    m_er = 1; m_stab = 0;
                end
                for (int i = 0; i < 4; i++) m_pres[i] = 0;
                m_pend = 0;
            end
            if (n == 1) begin
                for (int i = 0; i < 4; i++) begin
                    if (sel[i]) begin
                        m_slot[i] = m_decode(seg, i == 3);
                        m_pres[i] = 1;
                    end
                end
                m_pend = m_pres[0] && m_pres[1] && m_pres[2] && m_pres[3];
            end
        end
        if (m_cv) m_idle = 0;
        else if (m_idle == TOUT - 1) begin
            m_idle = 0; m_act = 0; m_stab = 0; m_pend = 0;
            for (int i = 0; i < 4; i++) m_pres[i] = 0;
        end else m_idle++;
    endtask

    // Per-cycle comparison of every output against the model.
    always @(negedge clock) begin
        if (chk_en) check("cycle", {2'b00, dut_vec()}, {2'b00, exp_vec});
    end

    // ---------------- stimulus helpers ----------------
    task automatic step(input logic [3:0] sel, input logic [6:0] seg);
        @(negedge clock);
        {D4, D3, D2, D1} = sel;
        {a, b, c, d, e, f, g} = seg;
        model_step(sel, seg);
        @(posedge clock);
        #1;
        exp_vec = model_vec();
    endtask

    task automatic idle(input int n);
        repeat (n) step(4'b0000, 7'h7F);
    endtask

    task automatic send(input int c0, c1, c2, c3, input int o0, o1, o2, o3);
        int cc [4];
        int oo [4];
        cc = '{c0, c1, c2, c3};
        oo = '{o0, o1, o2, o3};
        for (int k = 0; k < 4; k++) step(4'b0001 << oo[k], seg_tab[cc[oo[k]]]);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int cf [4];
        int pc [4];
        int od [4];
        logic [6:0] sg [4];
        logic [3:0] ill;
        bit have_prev;
        int j, t, r;

        #1 reset_n = 1'b0;
        #1;
        model_reset();
        check("reset_values", {2'b00, dut_vec()}, {2'b00, exp_vec});
        chk_en = 1;
        repeat (3) @(posedge clock);
        #1 reset_n = 1'b1;

        // Speed 42, scan order D2,D3,D4,D1
        send(13, 4, 2, 13, 1, 2, 3, 0);
        send(13, 4, 2, 13, 1, 2, 3, 0);
        idle(1);
        check("s42_valid", cadru_valid, 1);
        check("s42_digits", {cifra_zeci, cifra_unitati}, 8'h42);
        check("s42_activ", semnal_activ, 1);
        check("s42_cod", {cod_digit_1, cod_digit_2, cod_digit_3, cod_digit_4}, 16'hD42D);

        // Speed 7 with blank tens, then left turn
        repeat (2) send(13, 13, 7, 13, 0, 1, 2, 3);
        idle(1);
        check("s07_digits", {cifra_zeci, cifra_unitati}, 8'h07);
        repeat (2) send(11, 12, 12, 12, 3, 2, 1, 0);
        idle(1);
        check("left_flags", {semnal_stanga, semnal_dreapta, stop}, 3'b100);
        check("left_digits_held", {cifra_zeci, cifra_unitati}, 8'h07);

        repeat (2) send(12, 12, 12, 10, 0, 3, 1, 2);
        idle(1);
        check("right_flags", {semnal_stanga, semnal_dreapta, stop}, 3'b010);
        repeat (2) send(8, 8, 8, 8, 2, 0, 3, 1);
        idle(1);
        check("stop_flags", {semnal_stanga, semnal_dreapta, stop}, 3'b001);

        // Illegal selection mid-frame, then two clean frames of 55
        step(4'b0001, seg_tab[13]);
        step(4'b0010, seg_tab[5]);
        step(4'b0101, seg_tab[8]);
        check("illegal_err", {eroare_cadru, cadru_valid}, 2'b10);
        repeat (2) send(13, 5, 5, 13, 0, 1, 2, 3);
        idle(1);
        check("after_illegal", {cadru_valid, cifra_zeci, cifra_unitati}, 9'h155);

        // Undecodable pattern on D2
        send(13, 15, 2, 13, 0, 1, 2, 3);
        idle(1);
        check("bad_seg_err", {eroare_cadru, cadru_valid}, 2'b10);
        check("bad_seg_cod2", cod_digit_2, 4'd15);

        // Alternating 42/43 never commits
        for (int k = 0; k < 6; k++) send(13, 4, 2 + (k % 2), 13, 0, 1, 2, 3);
        idle(1);
        check("alt_no_commit", {cifra_zeci, cifra_unitati}, 8'h55);

        // Scanning halted
        idle(70);
        check("timeout_activ", semnal_activ, 0);
        check("timeout_held", {cifra_zeci, cifra_unitati}, 8'h55);

        // Randomized frames with noise, duplicates, illegal selections and gaps
        have_prev = 0;
        for (int fr = 0; fr < 120; fr++) begin
            r = $urandom_range(0, 9);
            if (have_prev && r < 5) cf = pc;
            else begin
                case ($urandom_range(0, 4))
                    0: begin
                        t = $urandom_range(0, 10);
                        cf = '{13, (t == 10) ? 13 : t, $urandom_range(0, 9), 13};
                    end
                    1: cf = '{11, 12, 12, 12};
                    2: cf = '{12, 12, 12, 10};
                    3: cf = '{8, 8, 8, 8};
                    default: cf = '{$urandom_range(0, 15), $urandom_range(0, 15),
                                    $urandom_range(0, 15), $urandom_range(0, 15)};
                endcase
            end
            pc = cf;
            have_prev = 1;
            for (int k = 0; k < 4; k++) sg[k] = seg_tab[cf[k]];
            if ($urandom_range(0, 19) == 0) sg[$urandom_range(0, 3)] = 7'($urandom);
            od = '{0, 1, 2, 3};
            for (int k = 3; k > 0; k--) begin
                j = $urandom_range(0, k);
                t = od[k]; od[k] = od[j]; od[j] = t;
            end
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(0, 7) == 0) step(4'b0000, 7'($urandom));
                if ($urandom_range(0, 39) == 0) begin
                    ill = 4'($urandom_range(3, 15));
                    if ($countones(ill) < 2) ill = 4'b1111;
                    step(ill, 7'($urandom));
                end
                if ($urandom_range(0, 14) == 0) step(4'b0001 << od[k], 7'($urandom));
                step(4'b0001 << od[k], sg[od[k]]);
            end
            if ($urandom_range(0, 24) == 0) idle($urandom_range(60, 70));
        end
        idle(2);

        // Asynchronous reset in the middle of a frame
        repeat (2) send(13, 9, 1, 13, 0, 1, 2, 3);
        step(4'b0010, seg_tab[3]);
        step(4'b0100, seg_tab[6]);
        #2 reset_n = 1'b0;
        #1;
        check("reset_async", {2'b00, dut_vec()}, {2'b00, 16'hDDDD, 14'b0});
        model_reset();
        {D4, D3, D2, D1} = 4'b0000;
        repeat (2) @(posedge clock);
        #1 reset_n = 1'b1;
        step(4'b0001, seg_tab[13]);
        idle(3);
        check("post_reset_quiet", {cadru_valid, eroare_cadru}, 2'b00);
        repeat (2) send(13, 6, 8, 13, 3, 0, 2, 1);
        idle(1);
        check("post_reset_commit", {semnal_activ, cifra_zeci, cifra_unitati}, 9'h168);

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end
endmodule
